ni_link_rx: RTL and testbench

//  Receive end of the NI transmit link: accepts one packet per req cycle from an NI's item_out/req,

---
 rtl/ni_link_rx_if.sv | 26 ++
 rtl/ni_link_rx.sv | 95 +++++++++
 tb/tb_ni_link_rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ni_link_rx_if.sv
// Link between a sending NI, the channel receive buffer and the receiving NI.
// slave = channel receive block, master = the NIs on either side.
interface ni_link_rx_if #(
    parameter int W = 17
);
    logic         req;
    logic [W-1:0] item_in;
    logic         channel_busy;
    logic [W-1:0] item_out;
    logic         valid;
    logic         busy;
    logic         parity_err;
    logic         overflow;
    logic [15:0]  rx_count;
    logic [7:0]   err_count;

    modport slave (
        input  req, item_in, busy,
        output channel_busy, item_out, valid, parity_err, overflow, rx_count, err_count
    );

    modport master (
        output req, item_in, busy,
        input  channel_busy, item_out, valid, parity_err, overflow, rx_count, err_count
    );
endinterface

// File: rtl/ni_link_rx.sv
// Parity-checking receive FIFO between a sending NI and a receiving NI; packet visible one cycle
// after capture; channel_busy raised at DEPTH-1 so the one in-flight packet still fits.
module ni_link_rx #(
    parameter int HDR_SZ   = 4,
    parameter int PL_SZ    = 8,
    parameter int ADDR_SZ  = 4,
    parameter int DEPTH    = 4,
    parameter bit DROP_BAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    ni_link_rx_if.slave lnk
);
    localparam int W  = HDR_SZ + PL_SZ + ADDR_SZ + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] BUSY_LVL = (AW+1)'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          parity_err_q, parity_err_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   rx_count_q, rx_count_d;
    logic [7:0]    err_count_q, err_count_d;

    logic good, full, vld, pop, push, bad_in;

    assign good   = (lnk.item_in[W-1] == ^lnk.item_in[W-2:0]);
    assign full   = (count_q == FULL_LVL);
    assign vld    = (count_q != '0);
    assign pop    = vld && !lnk.busy;
    assign bad_in = lnk.req && !good;
    // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
    assign push   = lnk.req && (good || !DROP_BAD) && (!full || pop);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        parity_err_d = parity_err_q;
        overflow_d   = overflow_q;
        rx_count_d   = rx_count_q;
        err_count_d  = err_count_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            rx_count_d = rx_count_q + 16'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (bad_in) begin
            parity_err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        if (lnk.req && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
            rx_count_q   <= '0;
            err_count_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
            rx_count_q   <= rx_count_d;
            err_count_q  <= err_count_d;
        end
    end

    // Storage needs no reset: stale entries are hidden by the pointers and the valid gate.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= lnk.item_in;
    end

    assign lnk.valid        = vld;
    assign lnk.item_out     = vld ? mem_q[rd_ptr_q] : '0;
    assign lnk.channel_busy = (count_q >= BUSY_LVL);
    assign lnk.parity_err   = parity_err_q;
    assign lnk.overflow     = overflow_q;
    assign lnk.rx_count     = rx_count_q;
    assign lnk.err_count    = err_count_q;
endmodule

// File: tb/tb_ni_link_rx.sv
// Directed bench for ni_link_rx: one instance drops bad packets, the other forwards them.
module tb_ni_link_rx;
    localparam int W = 17;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ni_link_rx_if #(.W(W)) lnk0 ();
    ni_link_rx_if #(.W(W)) lnk1 ();

    ni_link_rx #(.DEPTH(4), .DROP_BAD(1'b1)) u_drop (.clk(clk), .reset(reset), .lnk(lnk0));
    ni_link_rx #(.DEPTH(4), .DROP_BAD(1'b0)) u_fwd  (.clk(clk), .reset(reset), .lnk(lnk1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {parity, header, payload, dest}; flip forces a parity error
    function automatic logic [W-1:0] pkt(input logic [3:0] hdr, input logic [7:0] pl,
                                         input logic [3:0] dest, input bit flip);
        logic [W-2:0] body;
        body = {hdr, pl, dest};
        return {(^body) ^ flip, body};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        lnk0.req = 1'b0; lnk0.item_in = '0; lnk0.busy = 1'b0;
        lnk1.req = 1'b0; lnk1.item_in = '0; lnk1.busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [W-1:0] p [5];
    logic [W-1:0] bp;

    initial begin
        do_reset();
        // reset state
        check("rst_valid", 32'(lnk0.valid), 32'd0);
        check("rst_item", 32'(lnk0.item_out), 32'd0);
        check("rst_cbusy", 32'(lnk0.channel_busy), 32'd0);
        check("rst_rxcnt", 32'(lnk0.rx_count), 32'd0);
        check("rst_errcnt", 32'(lnk0.err_count), 32'd0);
        check("rst_flags", {30'd0, lnk0.parity_err, lnk0.overflow}, 32'd0);

        // 1: single good packet, one-cycle latency, popped immediately
        p[0] = pkt(4'h1, 8'd5, 4'd1, 1'b0);
        lnk0.req = 1'b1; lnk0.item_in = p[0];
        @(negedge clk);
        lnk0.req = 1'b0;
        check("t1_valid", 32'(lnk0.valid), 32'd1);
        check("t1_item", 32'(lnk0.item_out), 32'(p[0]));
        @(negedge clk);
        check("t1_drained", 32'(lnk0.valid), 32'd0);
        check("t1_rxcnt", 32'(lnk0.rx_count), 32'd1);

        // 2: parity error, dropped vs forwarded
        do_reset();
        bp = pkt(4'h2, 8'd9, 4'd3, 1'b1);
        lnk0.req = 1'b1; lnk0.item_in = bp; lnk1.req = 1'b1; lnk1.item_in = bp;
        lnk1.busy = 1'b1;
        @(negedge clk);
        lnk0.req = 1'b0; lnk1.req = 1'b0;
        check("t2_drop_valid", 32'(lnk0.valid), 32'd0);
        check("t2_drop_perr", 32'(lnk0.parity_err), 32'd1);
        check("t2_drop_errcnt", 32'(lnk0.err_count), 32'd1);
        check("t2_drop_rxcnt", 32'(lnk0.rx_count), 32'd0);
        check("t2_fwd_valid", 32'(lnk1.valid), 32'd1);
        check("t2_fwd_item", 32'(lnk1.item_out), 32'(bp));
        check("t2_fwd_errcnt", 32'(lnk1.err_count), 32'd1);

        // 3: fill under busy, in-flight 4th accepted, 5th overflows, then in-order drain
        do_reset();
        for (int i = 0; i < 5; i++) p[i] = pkt(4'h3, 8'(8'h10 + i), 4'd2, 1'b0);
        lnk0.busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lnk0.req = 1'b1; lnk0.item_in = p[i];
            @(negedge clk);
        end
        check("t3_cbusy_after3", 32'(lnk0.channel_busy), 32'd1);
        lnk0.item_in = p[3];
        @(negedge clk);
        check("t3_ovf_after4", 32'(lnk0.overflow), 32'd0);
        lnk0.item_in = p[4];
        @(negedge clk);
        lnk0.req = 1'b0;
        check("t3_ovf_after5", 32'(lnk0.overflow), 32'd1);
        check("t3_rxcnt", 32'(lnk0.rx_count), 32'd4);
        lnk0.busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_drain%0d", i), 32'(lnk0.item_out), 32'(p[i]));
            @(negedge clk);
        end
        check("t3_empty", 32'(lnk0.valid), 32'd0);

        // 4: push and pop on the same edge while full
        do_reset();
        for (int i = 0; i < 5; i++) p[i] = pkt(4'h4, 8'(8'h20 + i), 4'd5, 1'b0);
        lnk0.busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lnk0.req = 1'b1; lnk0.item_in = p[i];
            @(negedge clk);
        end
        lnk0.item_in = p[4]; lnk0.busy = 1'b0;
        @(negedge clk);
        lnk0.req = 1'b0;
        check("t4_no_ovf", 32'(lnk0.overflow), 32'd0);
        check("t4_cbusy", 32'(lnk0.channel_busy), 32'd1);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t4_order%0d", i), 32'(lnk0.item_out), 32'(p[i]));
            @(negedge clk);
        end
        check("t4_empty", 32'(lnk0.valid), 32'd0);

        // 5: asynchronous reset with data buffered
        do_reset();
        lnk0.busy = 1'b1;
        lnk0.req = 1'b1; lnk0.item_in = pkt(4'h5, 8'd1, 4'd1, 1'b0);
        @(negedge clk);
        lnk0.item_in = pkt(4'h5, 8'd2, 4'd1, 1'b0);
        @(negedge clk);
        lnk0.item_in = pkt(4'h5, 8'd3, 4'd1, 1'b1);
        @(negedge clk);
        lnk0.req = 1'b0;
        check("t5_pre_valid", 32'(lnk0.valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_valid", 32'(lnk0.valid), 32'd0);
        check("t5_item", 32'(lnk0.item_out), 32'd0);
        check("t5_rxcnt", 32'(lnk0.rx_count), 32'd0);
        check("t5_errcnt", 32'(lnk0.err_count), 32'd0);
        check("t5_perr", 32'(lnk0.parity_err), 32'd0);

        // 6: err_count saturation and rx_count wrap
        do_reset();
        for (int i = 0; i < 300; i++) begin
            lnk0.req = 1'b1; lnk0.item_in = pkt(4'h6, 8'(i), 4'd7, 1'b1);
            @(negedge clk);
        end
        lnk0.req = 1'b0;
        check("t6_errsat", 32'(lnk0.err_count), 32'd255);
        check("t6_bad_rx", 32'(lnk0.rx_count), 32'd0);
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            lnk0.req = 1'b1; lnk0.item_in = pkt(4'h7, 8'(i), 4'd7, 1'b0);
            @(negedge clk);
        end
        lnk0.req = 1'b0;
        @(negedge clk);
        check("t6_rxwrap", 32'(lnk0.rx_count), 32'd1);
        check("t6_drained", 32'(lnk0.valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
